// File: rtl/level_controller.sv
// Level sequencer for the playfield and level display: start, per-level load pulse,
// timed inter-level transition and final win. Optional debug skip: define LEVEL_SKIP_EN.
module level_controller #(
  parameter int FIRST_LEVEL       = 1,
  parameter int MAX_LEVEL         = 9,
  parameter int TRANSITION_FRAMES = 120
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startGame,
  input  logic       levelCleared,
  input  logic       gameOver,
  input  logic       skipLevel,
  output logic [3:0] level,
  output logic       levelLoad,
  output logic       levelTransition,
  output logic       gameWon
);

  localparam int CNT_W = $clog2(TRANSITION_FRAMES + 1);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(TRANSITION_FRAMES - 1);
  localparam logic [3:0] FIRST = 4'(FIRST_LEVEL);
  localparam logic [3:0] LAST  = 4'(MAX_LEVEL);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, TRANSITION, WON} stateT;

  stateT            state;
  logic [CNT_W-1:0] frameCnt;
  logic             clearEvent;

`ifdef LEVEL_SKIP_EN
  always_comb begin
    clearEvent = levelCleared | skipLevel;
  end
`else
  logic unusedSkipLevel;
  assign unusedSkipLevel = skipLevel;

  always_comb begin
    clearEvent = levelCleared;
  end
`endif

  // Outputs are set on the edge that enters a state, so each one lines up with the state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= IDLE;
      level           <= FIRST;
      levelLoad       <= 1'b0;
      levelTransition <= 1'b0;
      gameWon         <= 1'b0;
      frameCnt        <= '0;
    end else begin
      levelLoad <= 1'b0;
      case (state)
        IDLE: begin
          if (startGame) begin
            level     <= FIRST;
            levelLoad <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          state <= PLAY;
        end
        PLAY: begin
          if (gameOver) begin
            state <= IDLE;
          end else if (clearEvent) begin
            if (level >= LAST) begin
              gameWon <= 1'b1;
              state   <= WON;
            end else begin
              level           <= level + 4'd1;
              frameCnt        <= '0;
              levelTransition <= 1'b1;
              state           <= TRANSITION;
            end
          end
        end
        TRANSITION: begin
          if (gameOver) begin
            levelTransition <= 1'b0;
            state           <= IDLE;
          end else if (startOfFrame) begin
            frameCnt <= frameCnt + 1'b1;
            if (frameCnt == LAST_FRAME) begin
              levelTransition <= 1'b0;
              levelLoad       <= 1'b1;
              state           <= LOAD;
            end
          end
        end
        WON: begin
          if (startGame) begin
            gameWon   <= 1'b0;
            level     <= FIRST;
            levelLoad <= 1'b1;
            state     <= LOAD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
